// File: rtl/comparador_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
// Optional build macro: COMPARADOR_SIGNED_EN (two's-complement compare).
package comparador_pkg;

  // Default operand width of the comparator.
  localparam int N_DEFAULT = 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the bit counter for an n-bit operand (counts 0..n-1).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/celda_comparadora.sv
// Single combinational magnitude-comparator bit cell, fed LSB first.
// Optional build macro: COMPARADOR_SIGNED_EN -- when defined, msb_sel
// inverts the sense of the bit so a set sign bit means "smaller".
module celda_comparadora (
  input  logic a,
  input  logic b,
  input  logic gt_in,
  input  logic eq_in,
  input  logic msb_sel,
  output logic gt_out,
  output logic eq_out
);

  logic same;

  assign same   = ~(a ^ b);
  assign eq_out = same & eq_in;

`ifdef COMPARADOR_SIGNED_EN
  // A differing sign bit decides the result the opposite way round.
  assign gt_out = msb_sel ? ((~a & b) | (same & gt_in))
                          : ((a & ~b) | (same & gt_in));
`else
  // Unsigned build: the MSB is treated like every other bit.
  logic unused_msb_sel;
  assign unused_msb_sel = msb_sel;
  assign gt_out = (a & ~b) | (same & gt_in);
`endif

endmodule

// File: rtl/comparador_serial_ctrl.sv
// Sequencer for a bit-serial magnitude comparator: captures two N-bit
// words on start, runs one comparator cell over them LSB first, then
// reports greater/equal/less with a one-cycle done pulse.
// Optional build macro: COMPARADOR_SIGNED_EN (two's-complement compare).
module comparador_serial_ctrl
  import comparador_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] wordA,
  input  logic [N-1:0] wordB,
  output logic         busy,
  output logic         done,
  output logic         a_gt_b,
  output logic         a_eq_b,
  output logic         a_lt_b
);

  localparam int              CW       = cnt_width(N);
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

  state_t        state, state_next;
  logic [N-1:0]  sh_a, sh_b;
  logic [CW-1:0] cnt;
  logic          gt_acc, eq_acc;
  logic          last_bit;
  logic          gt_cell, eq_cell;

  // The bit being processed this cycle is the MSB of the captured words.
  assign last_bit = (state == ST_RUN) && (cnt == CNT_LAST);

  celda_comparadora u_celda (
    .a       (sh_a[0]),
    .b       (sh_b[0]),
    .gt_in   (gt_acc),
    .eq_in   (eq_acc),
    .msb_sel (last_bit),
    .gt_out  (gt_cell),
    .eq_out  (eq_cell)
  );

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the MSB,
  // DONE -> IDLE unconditionally.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)    state_next = ST_RUN;
      ST_RUN:  if (last_bit) state_next = ST_DONE;
      ST_DONE:               state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  // Operand capture, serial shifting, accumulators and result flags.
  // NOTE: the shift registers are reset too; they are a handful of flops,
  // not a memory, and a known value keeps abort behaviour deterministic.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_a   <= '0;
      sh_b   <= '0;
      cnt    <= '0;
      gt_acc <= 1'b0;
      eq_acc <= 1'b0;
      a_gt_b <= 1'b0;
      a_eq_b <= 1'b0;
      a_lt_b <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sh_a   <= wordA;
            sh_b   <= wordB;
            cnt    <= '0;
            gt_acc <= 1'b0;
            eq_acc <= 1'b1;
          end
        end
        ST_RUN: begin
          gt_acc <= gt_cell;
          eq_acc <= eq_cell;
          sh_a   <= {1'b0, sh_a[N-1:1]};
          sh_b   <= {1'b0, sh_b[N-1:1]};
          // Counter stops at the last bit instead of wrapping.
          if (!last_bit) cnt <= cnt + CW'(1);
          if (last_bit) begin
            a_gt_b <= gt_cell;
            a_eq_b <= eq_cell;
            a_lt_b <= ~gt_cell & ~eq_cell;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule
